osd_spi_master: RTL and testbench

//  SPI initiator driving the OSD overlay's command port (SCK/SS3/DI) from clk_sys. Accepts one

---
 rtl/osd_spi_master_if.sv | 29 ++
 rtl/osd_spi_master.sv | 152 +++++++++++++++
 tb/tb_osd_spi_master.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/osd_spi_master_if.sv
// Command, payload and SPI pin bundle for the OSD SPI initiator.
// Latency: none (wires only).
// Backpressure: cmd_ready / data_ready are driven by the master side.
interface osd_spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_line;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       SPI_SCK;
  logic       SPI_SS3;
  logic       SPI_DO;
  logic       busy;
  logic       done;

  // SPI initiator side
  modport master (
    input  cmd_valid, cmd_op, cmd_line, data, data_valid,
    output cmd_ready, data_ready, SPI_SCK, SPI_SS3, SPI_DO, busy, done
  );

  // Command / payload source side
  modport slave (
    output cmd_valid, cmd_op, cmd_line, data, data_valid,
    input  cmd_ready, data_ready, SPI_SCK, SPI_SS3, SPI_DO, busy, done
  );
endinterface

// File: rtl/osd_spi_master.sv
// SPI initiator for the OSD command port: enable/disable/write-line commands, MSB first.
// Latency: SS3 low the cycle after accept; 16*CLK_DIV cycles per byte, +1 per payload fetch.
// Backpressure: one command at a time (cmd_ready only in IDLE); payload stalls hold SCK low.
module osd_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int LINE_BYTES = 256
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  osd_spi_master_if.master bus
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [8:0]       LINE_MAX = 9'(LINE_BYTES);

  typedef enum logic [2:0] {IDLE, SHIFT, FETCH, TAIL, GAP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [8:0]       byte_cnt;   // payload bytes handed over so far
  logic [6:0]       shreg;      // bits still to be sent after the one on SPI_DO
  logic [1:0]       op_q;
  logic [7:0]       cmd_byte;
  logic             sck_q, ss3_q, do_q, done_q;

  logic div_wrap, cmd_acc, dat_acc, byte_end, more_data;

  assign div_wrap  = (div_cnt == DIV_MAX);
  assign cmd_acc   = bus.cmd_valid && (state == IDLE);
  assign dat_acc   = bus.data_valid && (state == FETCH);
  // 8th falling SCK edge of the current byte
  assign byte_end  = (state == SHIFT) && div_wrap && sck_q && (bit_cnt == 3'd7);
  assign more_data = (op_q == 2'd2) && (byte_cnt < LINE_MAX);

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.data_ready = (state == FETCH);
  assign bus.busy       = (state != IDLE);
  assign bus.SPI_SCK    = sck_q;
  assign bus.SPI_SS3    = ss3_q;
  assign bus.SPI_DO     = do_q;
  assign bus.done       = done_q;

  // Opcode to on-wire command byte
  always_comb begin
    cmd_byte = 8'h00;
    case (bus.cmd_op)
      2'd0:    cmd_byte = 8'h40;
      2'd1:    cmd_byte = 8'h41;
      2'd2:    cmd_byte = {5'b00100, bus.cmd_line};
      default: cmd_byte = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_acc) state_nxt = (bus.cmd_op == 2'd3) ? GAP : SHIFT;
      SHIFT: if (byte_end) state_nxt = more_data ? FETCH : TAIL;
      FETCH: if (dat_acc) state_nxt = SHIFT;
      TAIL:  if (div_wrap) state_nxt = GAP;
      GAP:   if (div_wrap && bit_cnt[0]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: SCK divider, shifter, counters and pin registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      op_q     <= '0;
      sck_q    <= 1'b0;
      ss3_q    <= 1'b1;
      do_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            op_q     <= bus.cmd_op;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            if (bus.cmd_op == 2'd3) begin
              // no-op: nothing on the wire, just report completion
              done_q <= 1'b1;
            end else begin
              ss3_q <= 1'b0;
              do_q  <= cmd_byte[7];
              shreg <= cmd_byte[6:0];
            end
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
            if (sck_q) begin
              // falling edge: advance to the next bit while SCK is low
              bit_cnt <= bit_cnt + 3'd1;
              do_q    <= shreg[6];
              shreg   <= {shreg[5:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        FETCH: begin
          if (dat_acc) begin
            do_q     <= bus.data[7];
            shreg    <= bus.data[6:0];
            div_cnt  <= '0;
            byte_cnt <= byte_cnt + 9'd1;
          end
        end
        TAIL: begin
          if (div_wrap) begin
            ss3_q   <= 1'b1;
            done_q  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          // two divider periods with SS3 high; bit_cnt[0] marks the second
          if (div_wrap) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_spi_master.sv
// Directed bench for osd_spi_master with a byte scoreboard on the SPI pins.
// Latency: checks cycle timing of SS3/done/cmd_ready relative to command accept.
// Backpressure: exercises payload stalls, async reset mid-line and ignored commands.
module tb_osd_spi_master;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  osd_spi_master_if bus ();

  osd_spi_master #(.CLK_DIV(2), .LINE_BYTES(256)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] sb_q[$];
  logic       prev_sck = 1'b0;
  logic       prev_do  = 1'b0;
  logic [7:0] mon_sh   = 8'h00;
  int         mon_nb   = 0;
  int         rises    = 0;
  int         first_lo, last_lo, done_k, done_cnt, ready_k, dr_cnt, busy_cnt;
  int         extra_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling clk edge and run the SPI pin monitor.
  task automatic tick();
    @(negedge clk_sys);
    if (!bus.SPI_SS3 && bus.SPI_SCK && !prev_sck) begin
      rises++;
      mon_sh = {mon_sh[6:0], bus.SPI_DO};
      mon_nb++;
      if (mon_nb == 8) begin
        mon_nb = 0;
        chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) chk("sb_byte", 32'(mon_sh), 32'(sb_q.pop_front()));
      end
    end
    if (prev_sck && bus.SPI_SCK) chk("do_stable_sck_hi", 32'(bus.SPI_DO), 32'(prev_do));
    if (bus.SPI_SS3) mon_nb = 0;
    prev_sck = bus.SPI_SCK;
    prev_do  = bus.SPI_DO;
  endtask

  // Issue one command and follow it cycle by cycle until cmd_ready returns.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] line, input int stall_len,
                         input int abort_at, input int pulse_at);
    int         g;
    int         feed;
    int         stall_left;
    int         abort_wait;
    logic [7:0] stall_do;
    logic       stalling;
    logic       hs;
    first_lo = 0; last_lo = 0; done_k = 0; done_cnt = 0; ready_k = 0;
    dr_cnt = 0; busy_cnt = 0; rises = 0;
    case (op)
      2'd0: sb_q.push_back(8'h40);
      2'd1: sb_q.push_back(8'h41);
      2'd2: begin
        sb_q.push_back({5'b00100, line});
        for (int i = 0; i < 256; i++) sb_q.push_back(i[7:0]);
      end
      default: ;
    endcase
    bus.cmd_op    = op;
    bus.cmd_line  = line;
    bus.cmd_valid = 1'b1;
    g = 0;
    while (!bus.cmd_ready && g < 100) begin tick(); g++; end
    chk("cmd_ready_wait", 32'(g < 100), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    feed = 0; stall_left = stall_len; abort_wait = 10; stall_do = 8'h00;
    for (int k = 1; k <= 9000; k++) begin
      if (!bus.SPI_SS3) begin
        if (first_lo == 0) first_lo = k;
        last_lo = k;
      end
      if (bus.done) begin done_cnt++; done_k = k; end
      if (bus.busy) busy_cnt++;
      if (bus.data_ready) dr_cnt++;
      if (bus.cmd_ready) begin ready_k = k; break; end
      stalling = (op == 2'd2) && (feed == 2) && (stall_left > 0);
      if (stalling && bus.data_ready) begin
        if (stall_left == stall_len) stall_do = {7'd0, bus.SPI_DO};
        chk("stall_sck_low", 32'(bus.SPI_SCK), 32'd0);
        chk("stall_do_hold", 32'(bus.SPI_DO), 32'(stall_do[0]));
        stall_left--;
      end
      bus.data_valid = !stalling;
      bus.data       = feed[7:0];
      hs             = bus.data_valid && bus.data_ready;
      bus.cmd_valid  = (k == pulse_at);
      bus.cmd_op     = 2'd0;
      if (abort_at > 0 && feed == abort_at) begin
        if (abort_wait == 0) begin
          #2 reset_n = 1'b0;
          #1;
          chk("abort_ss3_high", 32'(bus.SPI_SS3), 32'd1);
          chk("abort_sck_low", 32'(bus.SPI_SCK), 32'd0);
          chk("abort_busy_low", 32'(bus.busy), 32'd0);
          bus.data_valid = 1'b0;
          sb_q.delete();
          tick();
          tick();
          reset_n = 1'b1;
          tick();
          return;
        end
        abort_wait--;
      end
      tick();
      if (hs) feed++;
    end
    bus.data_valid = 1'b0;
    bus.cmd_valid  = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_line   = 3'd0;
    bus.data       = 8'h00;
    bus.data_valid = 1'b0;
    repeat (3) tick();
    chk("rst_ss3", 32'(bus.SPI_SS3), 32'd1);
    chk("rst_sck", 32'(bus.SPI_SCK), 32'd0);
    chk("rst_do", 32'(bus.SPI_DO), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_data_ready", 32'(bus.data_ready), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // enable, with a stray command pulse while busy
    run_cmd(2'd1, 3'd0, 0, 0, 10);
    chk("op1_ss3_first", 32'(first_lo), 32'd1);
    chk("op1_ss3_last", 32'(last_lo), 32'd34);
    chk("op1_done_at", 32'(done_k), 32'd35);
    chk("op1_done_cnt", 32'(done_cnt), 32'd1);
    chk("op1_ready_at", 32'(ready_k), 32'd39);
    chk("op1_sck_rises", 32'(rises), 32'd8);
    chk("op1_no_data_ready", 32'(dr_cnt), 32'd0);
    chk("op1_busy_cycles", 32'(busy_cnt), 32'd38);
    chk("op1_sb_empty", 32'(sb_q.size()), 32'd0);
    extra_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy || !bus.SPI_SS3) extra_busy++;
    end
    chk("pulse_ignored", 32'(extra_busy), 32'd0);

    // disable
    run_cmd(2'd0, 3'd0, 0, 0, 0);
    chk("op0_done_at", 32'(done_k), 32'd35);
    chk("op0_no_data_ready", 32'(dr_cnt), 32'd0);
    chk("op0_busy_cycles", 32'(busy_cnt), 32'd38);
    chk("op0_sck_rises", 32'(rises), 32'd8);
    chk("op0_sb_empty", 32'(sb_q.size()), 32'd0);

    // no-op
    run_cmd(2'd3, 3'd0, 0, 0, 0);
    chk("op3_done_at", 32'(done_k), 32'd1);
    chk("op3_done_cnt", 32'(done_cnt), 32'd1);
    chk("op3_no_ss3", 32'(first_lo), 32'd0);
    chk("op3_ready_at", 32'(ready_k), 32'd5);
    chk("op3_sck_rises", 32'(rises), 32'd0);

    // write line 5, data always valid
    run_cmd(2'd2, 3'd5, 0, 0, 0);
    chk("wr5_data_ready_cycles", 32'(dr_cnt), 32'd256);
    chk("wr5_sck_rises", 32'(rises), 32'd2056);
    chk("wr5_ss3_first", 32'(first_lo), 32'd1);
    chk("wr5_ss3_last", 32'(last_lo), 32'd8482);
    chk("wr5_done_at", 32'(done_k), 32'd8483);
    chk("wr5_ready_at", 32'(ready_k), 32'd8487);
    chk("wr5_sb_empty", 32'(sb_q.size()), 32'd0);

    // write line 7, 10-cycle stall before the third payload byte
    run_cmd(2'd2, 3'd7, 10, 0, 0);
    chk("wr7_data_ready_cycles", 32'(dr_cnt), 32'd266);
    chk("wr7_sck_rises", 32'(rises), 32'd2056);
    chk("wr7_ss3_last", 32'(last_lo), 32'd8492);
    chk("wr7_ready_at", 32'(ready_k), 32'd8497);
    chk("wr7_sb_empty", 32'(sb_q.size()), 32'd0);

    // reset in the middle of payload byte 40, then a clean enable
    run_cmd(2'd2, 3'd3, 0, 40, 0);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    run_cmd(2'd1, 3'd0, 0, 0, 0);
    chk("post_rst_sck_rises", 32'(rises), 32'd8);
    chk("post_rst_done_at", 32'(done_k), 32'd35);
    chk("post_rst_ready_at", 32'(ready_k), 32'd39);
    chk("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
